// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word loads and stores onto a word-wide data memory with big-endian byte lanes.
// Latency: response 1 cycle after accept on error, 2 for loads and word stores, 3 for sub-word stores.
// Backpressure: req_ready only while idle; nothing is queued while an access is in flight.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave lsu
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic [1:0]  state;
    logic        lat_write;
    logic        lat_signed;
    logic        lat_err;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] word_buf;

    logic        bad_req;
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    always_comb begin
        bad_req = 1'b0;
        case (lsu.req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = lsu.req_addr[0];
            2'b10:   bad_req = (lsu.req_addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
        if ({2'b00, lsu.req_addr[31:2]} >= MEM_WORDS_W) bad_req = 1'b1;
    end

    // Offset 0 is the most significant lane, so the shift counts down from the top.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hffff_ffff;
        case (lat_size)
            2'b00: begin
                shamt     = {~lat_addr[1:0], 3'b000};
                lane_mask = 32'h0000_00ff << shamt;
            end
            2'b01: begin
                shamt     = {~lat_addr[1], 4'b0000};
                lane_mask = 32'h0000_ffff << shamt;
            end
            default: begin
                shamt     = 5'd0;
                lane_mask = 32'hffff_ffff;
            end
        endcase
    end

    assign merged_word = (word_buf & ~lane_mask) | ((lat_wdata << shamt) & lane_mask);
    assign byte_lane   = 8'(word_buf >> shamt);
    assign half_lane   = 16'(word_buf >> shamt);

    always_comb begin
        case (lat_size)
            2'b00:   ext_data = {{24{lat_signed & byte_lane[7]}}, byte_lane};
            2'b01:   ext_data = {{16{lat_signed & half_lane[15]}}, half_lane};
            default: ext_data = word_buf;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            word_buf   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        lat_write  <= lsu.req_write;
                        lat_signed <= lsu.req_signed;
                        lat_size   <= lsu.req_size;
                        lat_addr   <= lsu.req_addr;
                        lat_wdata  <= lsu.req_wdata;
                        lat_err    <= bad_req;
                        if (bad_req)
                            state <= RESP;
                        else if (lsu.req_write && lsu.req_size == 2'b10)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    word_buf <= lsu.mem_rdata;
                    state    <= lat_write ? WRITE : RESP;
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign lsu.req_ready  = (state == IDLE);
    assign lsu.resp_valid = (state == RESP);
    assign lsu.resp_error = (state == RESP) && lat_err;
    assign lsu.resp_rdata = ((state == RESP) && !lat_err && !lat_write) ? ext_data : 32'h0;
    assign lsu.mem_read   = (state == READ);
    assign lsu.mem_write  = (state == WRITE);
    assign lsu.mem_addr   = ((state == READ) || (state == WRITE)) ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign lsu.mem_wdata  = (state == WRITE) ? merged_word : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int MEM_WORDS = 256;

    logic clk;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment memory (word array) driven by the DUT
    logic [31:0] dmem [0:MEM_WORDS-1];
    logic        mem_clr;
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    assign bus.mem_rdata = (bus.mem_addr[31:10] == 22'd0) ? dmem[bus.mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= 32'h0;
        end else if (bus.mem_write && bus.mem_addr[31:10] == 22'd0) begin
            dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end else if (pl_en) begin
            dmem[pl_idx] <= pl_dat;
        end
    end

    // Reference model: flat byte memory, big-endian words
    logic [7:0] refb [0:MEM_WORDS*4-1];

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = a[9:2];
        pl_dat = w;
        @(posedge clk);
        #1 pl_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * (3 - i));
            refb[int'(a[9:2]) * 4 + i] = t[7:0];
        end
    endtask

    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_er,
                         output int e_lat, output int e_nrd, output int e_nwr, output logic [31:0] e_wdat);
        int n;
        int base;
        logic [31:0] v;
        logic [31:0] t;
        e_rd = 32'h0; e_wdat = 32'h0; e_nrd = 0; e_nwr = 0; e_lat = 1;
        e_er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
               (a >= 32'(MEM_WORDS * 4));
        if (e_er) return;
        n = 1 << sz;
        base = int'(a[9:0]);
        if (!w) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, refb[base + i]};
            if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hffff_ffff << (8 * n));
            e_rd = v; e_lat = 2; e_nrd = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                t = wd >> (8 * (n - 1 - i));
                refb[base + i] = t[7:0];
            end
            e_lat = (n == 4) ? 2 : 3;
            e_nrd = (n == 4) ? 0 : 1;
            e_nwr = 1;
            base = base & ~3;
            e_wdat = {refb[base], refb[base + 1], refb[base + 2], refb[base + 3]};
        end
    endtask

    // Drives one request and records what the DUT did; lat = -1 means no response in time
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er,
                           output int nrd, output int nwr, output logic [31:0] wdat,
                           output logic mem_ok, output logic quiet_ok);
        int waited;
        lat = -1; rd = 32'h0; er = 1'b0; nrd = 0; nwr = 0; wdat = 32'h0; mem_ok = 1'b1; quiet_ok = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        waited = 0;
        while (!bus.req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.req_valid = 1'b0; bus.req_write = $urandom_range(0, 1); bus.req_size = 2'($urandom());
                bus.req_signed = $urandom_range(0, 1); bus.req_addr = $urandom(); bus.req_wdata = $urandom();
            end
            if (bus.req_ready) quiet_ok = 1'b0;
            if (bus.mem_read && bus.mem_write) mem_ok = 1'b0;
            if ((bus.mem_read || bus.mem_write) && bus.mem_addr !== {a[31:2], 2'b00}) mem_ok = 1'b0;
            if (bus.mem_read) nrd++;
            if (bus.mem_write) begin
                nwr++;
                wdat = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                lat = cyc; rd = bus.resp_rdata; er = bus.resp_error;
                break;
            end else if (bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0) begin
                quiet_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else pass_cnt++;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write} !== 4'b0000)
            $display("FAIL reset_strobes got %b want 0000",
                     {bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write});
        else pass_cnt++;
        total_cnt++;
        if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0)
            $display("FAIL reset_buses got %h/%h/%h want 0", bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_word_store_load();
        int lat, nrd, nwr; logic [31:0] rd, wdat; logic er, mok, qok;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr, wdat, mok, qok);
        for (int i = 0; i < 4; i++) refb[16 + i] = 8'(32'hDEADBEEF >> (24 - 8 * i));
        total_cnt++;
        if (lat !== 2 || nwr !== 1 || nrd !== 0 || er !== 1'b0)
            $display("FAIL wstore_timing got lat=%0d wr=%0d rd=%0d err=%b want 2/1/0/0", lat, nwr, nrd, er);
        else pass_cnt++;
        total_cnt++;
        if (wdat !== 32'hDEADBEEF || !mok) $display("FAIL wstore_data got %h ok=%b want deadbeef", wdat, mok);
        else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, er, nrd, nwr, wdat, mok, qok);
        total_cnt++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || !qok)
            $display("FAIL wload got lat=%0d data=%h err=%b want 2/deadbeef/0", lat, rd, er);
        else pass_cnt++;
    endtask

    task automatic test_subword();
        int lat, nrd, nwr; logic [31:0] rd, wdat; logic er, mok, qok;
        logic [31:0] addrs [4]; logic [1:0] sizes [4]; logic sgns [4]; logic [31:0] exps [4];
        preload(32'h20, 32'h11223344);
        run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, rd, er, nrd, nwr, wdat, mok, qok);
        total_cnt++;
        if (rd !== 32'h00000022 || lat !== 2) $display("FAIL sbyte_21 got %h lat=%0d want 00000022/2", rd, lat);
        else pass_cnt++;
        run_req(1'b1, 2'b00, 1'b0, 32'h23, 32'hF0, lat, rd, er, nrd, nwr, wdat, mok, qok);
        refb[32'h23] = 8'hF0;
        total_cnt++;
        if (wdat !== 32'h112233F0 || lat !== 3 || nrd !== 1 || nwr !== 1 || !mok)
            $display("FAIL bstore_23 got %h lat=%0d rd=%0d wr=%0d want 112233f0/3/1/1", wdat, lat, nrd, nwr);
        else pass_cnt++;
        preload(32'h30, 32'h80FF7F01);
        addrs = '{32'h30, 32'h32, 32'h31, 32'h33};
        sizes = '{2'b01, 2'b01, 2'b00, 2'b00};
        sgns  = '{1'b1, 1'b0, 1'b1, 1'b1};
        exps  = '{32'hFFFF80FF, 32'h00007F01, 32'hFFFFFFFF, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, rd, er, nrd, nwr, wdat, mok, qok);
            total_cnt++;
            if (rd !== exps[i] || er !== 1'b0)
                $display("FAIL ext_load_%0d got %h err=%b want %h", i, rd, er, exps[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        int lat, nrd, nwr; logic [31:0] rd, wdat; logic er, mok, qok;
        logic ws [4]; logic [1:0] szs [4]; logic [31:0] as [4];
        ws  = '{1'b0, 1'b1, 1'b0, 1'b0};
        szs = '{2'b10, 2'b01, 2'b11, 2'b10};
        as  = '{32'h06, 32'h05, 32'h00, 32'h400};
        for (int i = 0; i < 4; i++) begin
            run_req(ws[i], szs[i], 1'b0, as[i], 32'hFFFF_FFFF, lat, rd, er, nrd, nwr, wdat, mok, qok);
            total_cnt++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0)
                $display("FAIL err_%0d got lat=%0d err=%b data=%h rd=%0d wr=%0d want 1/1/0/0/0",
                         i, lat, er, rd, nrd, nwr);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_write();
        int lat, nrd, nwr; logic [31:0] rd, wdat; logic er, mok, qok;
        logic saw_resp, saw_wr;
        preload(32'h40, 32'h01234567);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'hABCD;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.mem_write !== 1'b1) $display("FAIL rst_wr_before got %b want 1", bus.mem_write); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
            $display("FAIL rst_async got wr=%b rdy=%b vld=%b want 0/1/0", bus.mem_write, bus.req_ready, bus.resp_valid);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        saw_resp = 1'b0; saw_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) saw_resp = 1'b1;
            if (bus.mem_write || !bus.req_ready) saw_wr = 1'b1;
        end
        total_cnt++;
        if (saw_resp || saw_wr || dmem[16] !== 32'h01234567)
            $display("FAIL rst_abort got resp=%b busy=%b mem=%h want 0/0/01234567", saw_resp, saw_wr, dmem[16]);
        else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, nrd, nwr, wdat, mok, qok);
        total_cnt++;
        if (rd !== 32'h01234567 || lat !== 2 || er !== 1'b0)
            $display("FAIL rst_next_load got %h lat=%0d want 01234567/2", rd, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc_cyc [2]; int resp_cyc [2]; logic [31:0] rds [2]; logic [31:0] exp [2];
        int n_acc, n_resp, busy; logic acc_now;
        int el, enr, enw; logic eer; logic [31:0] ewd;
        model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, exp[0], eer, el, enr, enw, ewd);
        model(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, exp[1], eer, el, enr, enw, ewd);
        acc_cyc = '{-1, -1}; resp_cyc = '{-1, -1}; rds = '{32'h0, 32'h0};
        n_acc = 0; n_resp = 0; busy = 0; acc_now = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (acc_now) begin
                if (n_acc == 1) bus.req_addr = 32'h20;
                else bus.req_valid = 1'b0;
            end
            acc_now = 1'b0;
            if (bus.resp_valid) begin
                if (n_resp < 2) begin resp_cyc[n_resp] = cyc; rds[n_resp] = bus.resp_rdata; end
                n_resp++;
            end
            if (!bus.req_ready) busy++;
            if (bus.req_valid && bus.req_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
                acc_now = 1'b1;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        total_cnt++;
        if (n_acc !== 2 || n_resp !== 2) $display("FAIL b2b_counts got acc=%0d resp=%0d want 2/2", n_acc, n_resp);
        else pass_cnt++;
        total_cnt++;
        if (acc_cyc[1] !== resp_cyc[0] + 1 || resp_cyc[0] - acc_cyc[0] !== 2 || resp_cyc[1] - acc_cyc[1] !== 2)
            $display("FAIL b2b_timing got acc=%0d,%0d resp=%0d,%0d want second accept right after first resp",
                     acc_cyc[0], acc_cyc[1], resp_cyc[0], resp_cyc[1]);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 4) $display("FAIL b2b_busy got %0d not-ready cycles want 4", busy); else pass_cnt++;
        total_cnt++;
        if (rds[0] !== exp[0] || rds[1] !== exp[1])
            $display("FAIL b2b_data got %h,%h want %h,%h", rds[0], rds[1], exp[0], exp[1]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, nrd, nwr, el, enr, enw, bad;
        logic [31:0] rd, wdat, erd, ewd, a, wd; logic er, eer, mok, qok, w, sg; logic [1:0] sz;
        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'h400 + $urandom_range(0, 32'hFFFF);
            else begin
                a = $urandom_range(0, MEM_WORDS * 4 - 1);
                if (sz == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
                if (sz == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            end
            model(w, sz, sg, a, wd, erd, eer, el, enr, enw, ewd);
            run_req(w, sz, sg, a, wd, lat, rd, er, nrd, nwr, wdat, mok, qok);
            total_cnt++;
            if (lat !== el || er !== eer) $display("FAIL rnd%0d_lat got %0d/%b want %0d/%b", k, lat, er, el, eer);
            else pass_cnt++;
            total_cnt++;
            if (rd !== erd) $display("FAIL rnd%0d_rdata got %h want %h", k, rd, erd); else pass_cnt++;
            total_cnt++;
            if (nrd !== enr || nwr !== enw) $display("FAIL rnd%0d_mem got rd=%0d wr=%0d want %0d/%0d", k, nrd, nwr, enr, enw);
            else pass_cnt++;
            total_cnt++;
            if (wdat !== ewd) $display("FAIL rnd%0d_wdata got %h want %h", k, wdat, ewd); else pass_cnt++;
            total_cnt++;
            if (!mok || !qok) $display("FAIL rnd%0d_proto got addr_ok=%b idle_ok=%b want 1/1", k, mok, qok);
            else pass_cnt++;
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (dmem[i] !== {refb[4 * i], refb[4 * i + 1], refb[4 * i + 2], refb[4 * i + 3]}) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL mem_image got %0d differing words want 0", bad); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_idx = 8'h0; pl_dat = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < MEM_WORDS * 4; i++) refb[i] = 8'h0;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        reset = 1'b0;
        test_word_store_load();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_in_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
